// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the two-master SRAM port arbiter.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    // Wide enough for any hold limit in 1..255
    localparam int HOLD_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic mid_t;
    localparam mid_t M0 = 1'b0;
    localparam mid_t M1 = 1'b1;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic arb_state_e own_state(input mid_t id);
        return (id == M1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Avalon-MM style master bus as seen by the arbiter (one instance per master).
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]           address;
    logic [be_width(DATA_W)-1:0] byteenable;
    logic                        read;
    logic                        write;
    logic [DATA_W-1:0]           writedata;
    logic                        lock;
    logic                        waitrequest;
    logic [DATA_W-1:0]           readdata;
    logic                        readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sram_port_arbiter_rr_grant2.sv
// Combinational 2-way round-robin picker with lock and hold-limit override.
module rr_grant2
    import sram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic       i_owner_vld,
    input  mid_t       i_owner,
    input  mid_t       i_last,
    input  logic       i_hold_hit,
    output logic       o_gnt_vld,
    output mid_t       o_gnt
);
    mid_t w_other;
    logic w_keep;

    // Owner keeps the grant if the other side is idle, or if it locks and
    // has not yet used up its hold budget; otherwise hand over.
    always_comb begin
        w_other   = ~i_owner;
        w_keep    = i_req[i_owner] &&
                    (!i_req[w_other] || (i_lock[i_owner] && !i_hold_hit));
        // Someone always wins whenever anyone requests: no bubbles.
        o_gnt_vld = |i_req;
        o_gnt     = M0;
        if (i_owner_vld) begin
            if (w_keep)
                o_gnt = i_owner;
            else
                o_gnt = w_other;
        end else begin
            if (i_req == 2'b11)
                o_gnt = ~i_last;
            else if (i_req[1])
                o_gnt = M1;
            else
                o_gnt = M0;
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port (registered address, 1-cycle read) between two
// Avalon-MM masters with round-robin, lock and a starvation hold limit.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_port_arbiter_if.slave    m0,
    sram_port_arbiter_if.slave    m1,
    output logic [ADDR_W-1:0]     sram_address,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W-1:0]     sram_writedata,
    output logic                  sram_clken,
    input  logic [DATA_W-1:0]     sram_readdata
);
    localparam int BE_W = be_width(DATA_W);

    arb_state_e        r_state, w_state_nxt;
    mid_t              r_last, r_rd_owner;
    logic              r_rd_pend;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;

    logic [1:0] w_req, w_lock;
    logic       w_owner_vld, w_hold_hit, w_gnt_vld, w_accept;
    logic       w_other_req, w_switch, w_wr, w_rd;
    mid_t       w_owner, w_gnt;
    logic [BE_W-1:0] w_be;

    assign w_req       = {m1.read | m1.write, m0.read | m0.write};
    assign w_lock      = {m1.lock, m0.lock};
    assign w_owner_vld = (r_state != IDLE);
    assign w_owner     = (r_state == OWN1) ? M1 : M0;
    assign w_hold_hit  = (r_hold >= HOLD_W'(MAX_HOLD));

    rr_grant2 u_grant (
        .i_req       (w_req),
        .i_lock      (w_lock),
        .i_owner_vld (w_owner_vld),
        .i_owner     (w_owner),
        .i_last      (r_last),
        .i_hold_hit  (w_hold_hit),
        .o_gnt_vld   (w_gnt_vld),
        .o_gnt       (w_gnt)
    );

    // The winner never waits, so a grant is an accept (except in reset).
    assign w_accept    = reset_n & w_gnt_vld;
    assign w_other_req = w_req[~w_gnt];
    assign w_switch    = !w_owner_vld || (w_owner != w_gnt);
    // Write wins if a master illegally raises both read and write.
    assign w_wr        = (w_gnt == M1) ? m1.write : m0.write;
    assign w_rd        = ((w_gnt == M1) ? m1.read : m0.read) & ~w_wr;
    assign w_be        = (w_gnt == M1) ? m1.byteenable : m0.byteenable;

    assign sram_address    = (w_gnt == M1) ? m1.address   : m0.address;
    assign sram_writedata  = (w_gnt == M1) ? m1.writedata : m0.writedata;
    assign sram_byteenable = w_be;
    assign sram_chipselect = w_accept;
    assign sram_write      = w_accept & w_wr;
    assign sram_clken      = 1'b1;

    assign m0.waitrequest   = !(w_accept && (w_gnt == M0));
    assign m1.waitrequest   = !(w_accept && (w_gnt == M1));
    assign m0.readdata      = sram_readdata;
    assign m1.readdata      = sram_readdata;
    assign m0.readdatavalid = r_rd_pend && (r_rd_owner == M0);
    assign m1.readdatavalid = r_rd_pend && (r_rd_owner == M1);

    // Next owner and hold counter; the accept that takes the grant counts
    // as the first of the new owner's run when the other side is waiting.
    always_comb begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
        if (w_accept) begin
            w_state_nxt = own_state(w_gnt);
            if (w_other_req) begin
                if (w_switch)
                    w_hold_nxt = HOLD_W'(1);
                else if (!w_hold_hit)
                    w_hold_nxt = r_hold + HOLD_W'(1);
                else
                    w_hold_nxt = r_hold;
            end
        end
    end

    // Arbitration state: owner, hold run length and last winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= M1;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_accept)
                r_last <= w_gnt;
        end
    end

    // Read return tracking: SRAM q is valid the cycle after the accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= M0;
        end else begin
            r_rd_pend <= w_accept & w_rd;
            if (w_accept & w_rd)
                r_rd_owner <= w_gnt;
        end
    end

    ap_m0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(m0.read && m0.write));
    ap_m1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(m1.read && m1.write));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, directed sequences and random
// traffic checked against a behavioural arbitration/memory model.
module tb_sram_port_arbiter;
    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        reset_n;
    logic [9:0]  sram_address;
    logic [3:0]  sram_byteenable;
    logic        sram_chipselect, sram_write, sram_clken;
    logic [31:0] sram_writedata, sram_readdata;

    sram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0_if ();
    sram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1_if ();

    sram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0              (m0_if),
        .m1              (m1_if),
        .sram_address    (sram_address),
        .sram_byteenable (sram_byteenable),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .sram_clken      (sram_clken),
        .sram_readdata   (sram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM port: registered address, unregistered q
    logic [31:0] mem [1024];
    logic [9:0]  sram_areg;
    always @(posedge clk) begin
        if (sram_chipselect && sram_clken) begin
            sram_areg <= sram_address;
            if (sram_write)
                for (int b = 0; b < 4; b++)
                    if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
        end
    end
    assign sram_readdata = mem[sram_areg];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: owner -1 = nobody took a transfer last cycle
    int          md_owner, md_last, md_streak;
    bit          md_pv, md_pk;
    int          md_po;
    bit [31:0]   md_pd;
    bit [31:0]   shadow [1024];
    bit          known  [1024];

    function automatic void mdl_reset();
        md_owner = -1; md_last = 1; md_streak = 0; md_pv = 0;
    endfunction

    function automatic int mdl_pick(input bit [1:0] rq, input bit [1:0] lk);
        int o, x;
        if (rq == 2'b00) return -1;
        if (md_owner < 0) begin
            if (rq == 2'b11) return 1 - md_last;
            return rq[0] ? 0 : 1;
        end
        o = md_owner; x = 1 - o;
        if (rq[o] && (!rq[x] || (lk[o] && md_streak < MAX_HOLD))) return o;
        return x;
    endfunction

    logic        smp_wr0, smp_wr1, smp_cs, smp_we, smp_rdv0, smp_rdv1;
    logic [31:0] smp_rd0, smp_rd1;
    logic [9:0]  smp_addr;
    int          acc;

    // One bus cycle: inputs already driven; check at negedge, advance model.
    task automatic tick();
        bit [1:0]  rq, lk;
        int        w;
        bit        wr;
        bit [9:0]  a;
        bit [3:0]  be;
        bit [31:0] d;
        @(negedge clk);
        if (!reset_n) mdl_reset();
        rq = {m1_if.read | m1_if.write, m0_if.read | m0_if.write};
        lk = {m1_if.lock, m0_if.lock};
        w  = reset_n ? mdl_pick(rq, lk) : -1;
        smp_wr0 = m0_if.waitrequest;    smp_wr1 = m1_if.waitrequest;
        smp_cs  = sram_chipselect;      smp_we  = sram_write;
        smp_rdv0 = m0_if.readdatavalid; smp_rdv1 = m1_if.readdatavalid;
        smp_rd0 = m0_if.readdata;       smp_rd1 = m1_if.readdata;
        smp_addr = sram_address;
        wr = 0; a = 0; be = 0; d = 0;
        if (w == 0) begin wr = m0_if.write; a = m0_if.address; be = m0_if.byteenable; d = m0_if.writedata; end
        if (w == 1) begin wr = m1_if.write; a = m1_if.address; be = m1_if.byteenable; d = m1_if.writedata; end
        chk("m0_waitrequest", 32'(smp_wr0), 32'(w != 0));
        chk("m1_waitrequest", 32'(smp_wr1), 32'(w != 1));
        chk("sram_chipselect", 32'(smp_cs), 32'(w >= 0));
        chk("sram_write", 32'(smp_we), 32'(w >= 0 && wr));
        chk("sram_clken", 32'(sram_clken), 32'd1);
        if (w >= 0) begin
            chk("sram_address", 32'(smp_addr), 32'(a));
            chk("sram_byteenable", 32'(sram_byteenable), 32'(be));
            if (wr) chk("sram_writedata", sram_writedata, d);
        end
        chk("m0_readdatavalid", 32'(smp_rdv0), 32'(md_pv && md_po == 0));
        chk("m1_readdatavalid", 32'(smp_rdv1), 32'(md_pv && md_po == 1));
        if (md_pv && md_pk)
            chk("readdata", (md_po == 0) ? smp_rd0 : smp_rd1, md_pd);
        acc = w;
        // state after the coming edge
        md_pv = 0;
        if (w < 0) begin
            md_owner = -1; md_streak = 0;
        end else begin
            if (rq[1-w]) md_streak = (md_owner == w) ? ((md_streak < MAX_HOLD) ? md_streak + 1 : md_streak) : 1;
            else         md_streak = 0;
            md_owner = w; md_last = w;
            if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
                if (be == 4'hF) known[a] = 1;
            end else begin
                md_pv = 1; md_po = w; md_pd = shadow[a]; md_pk = known[a];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int m, input bit rd, input bit wr, input bit lk,
                       input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.lock = lk;
            m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.lock = lk;
            m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 0, 10'h0, 4'h0, 32'h0);
        drv(1, 0, 0, 0, 10'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Fields: r0 w0 l0 r1 w1 l1 | exp wait0 wait1 cs we rdv0 rdv1
    typedef struct packed {
        bit r0, w0, l0, r1, w1, l1;
        bit ew0, ew1, ecs, ewe, ev0, ev1;
    } vec_t;
    vec_t tbl [13];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, first_m1, m1_acc, wait_run, max_wait, cyc;

        tbl[0]  = 12'b000_000_11_00_00;  // nobody
        tbl[1]  = 12'b000_100_10_10_00;  // m1 alone, zero-wait from idle
        tbl[2]  = 12'b100_100_01_10_01;  // contention, rotate to m0
        tbl[3]  = 12'b100_100_10_10_10;  // rotate back to m1
        tbl[4]  = 12'b000_000_11_00_01;  // idle, m1 read returns
        tbl[5]  = 12'b010_010_01_11_00;  // idle, last=m1 -> m0
        tbl[6]  = 12'b011_010_01_11_00;  // m0 locks, keeps grant
        tbl[7]  = 12'b010_100_10_10_00;  // lock dropped -> m1
        tbl[8]  = 12'b010_000_01_11_01;  // m1 gone, m0 takes it, no bubble
        tbl[9]  = 12'b100_000_01_10_00;  // m0 alone keeps going
        tbl[10] = 12'b000_000_11_00_10;  // m0 read returns
        tbl[11] = 12'b100_100_10_10_00;  // idle, last=m0 -> m1
        tbl[12] = 12'b000_000_11_00_01;

        mdl_reset();
        for (int i = 0; i < 1024; i++) known[i] = 0;
        idle_all();
        reset_n = 1'b0;
        #2;

        // vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drv(0, tbl[i].r0, tbl[i].w0, tbl[i].l0, 10'h010, 4'hF, 32'h0F0F0000 + 32'(i));
            drv(1, tbl[i].r1, tbl[i].w1, tbl[i].l1, 10'h020, 4'hF, 32'hF0F00000 + 32'(i));
            tick();
            chk($sformatf("vec%0d_wait0", i), 32'(smp_wr0), 32'(tbl[i].ew0));
            chk($sformatf("vec%0d_wait1", i), 32'(smp_wr1), 32'(tbl[i].ew1));
            chk($sformatf("vec%0d_cs", i), 32'(smp_cs), 32'(tbl[i].ecs));
            chk($sformatf("vec%0d_we", i), 32'(smp_we), 32'(tbl[i].ewe));
            chk($sformatf("vec%0d_rdv0", i), 32'(smp_rdv0), 32'(tbl[i].ev0));
            chk($sformatf("vec%0d_rdv1", i), 32'(smp_rdv1), 32'(tbl[i].ev1));
            if (tbl[i].ecs)
                chk($sformatf("vec%0d_addr", i), 32'(smp_addr), tbl[i].ew0 ? 32'h020 : 32'h010);
        end
        idle_all();
        tick();

        // write then read back on consecutive cycles
        do_reset();
        drv(0, 0, 1, 0, 10'h005, 4'hF, 32'hDEADBEEF);
        tick();
        chk("wr_rd_wait_wr", 32'(smp_wr0), 32'd0);
        drv(0, 1, 0, 0, 10'h005, 4'hF, 32'h0);
        tick();
        chk("wr_rd_wait_rd", 32'(smp_wr0), 32'd0);
        chk("wr_rd_early_rdv", 32'(smp_rdv0), 32'd0);
        idle_all();
        tick();
        chk("wr_rd_rdv", 32'(smp_rdv0), 32'd1);
        chk("wr_rd_data", smp_rd0, 32'hDEADBEEF);
        chk("wr_rd_m1_rdv", 32'(smp_rdv1), 32'd0);

        // locked stream vs hold limit
        do_reset();
        n0 = 0; first_m1 = -1; m1_acc = 0; wait_run = 0; max_wait = 0; cyc = 0;
        drv(1, 1, 0, 0, 10'h020, 4'hF, 32'h0);
        while (n0 < 20 && cyc < 100) begin
            drv(0, 0, 1, 1, 10'h100 + 10'(n0), 4'hF, 32'hA5000000 + 32'(n0));
            tick();
            cyc++;
            if (acc == 0) n0++;
            if (acc == 1) begin
                m1_acc++;
                if (first_m1 < 0) first_m1 = n0;
                wait_run = 0;
            end else begin
                wait_run++;
                if (wait_run > max_wait) max_wait = wait_run;
            end
        end
        chk("lock_stream_done", 32'(n0), 32'd20);
        chk("lock_m0_run_before_m1", 32'(first_m1), 32'd8);
        chk("lock_m1_accepts", 32'(m1_acc), 32'd2);
        chk("lock_m1_max_wait", 32'(max_wait), 32'd8);
        drv(0, 0, 0, 0, 10'h0, 4'h0, 32'h0);
        tick();
        chk("lock_m1_alone", 32'(smp_wr1), 32'd0);
        idle_all();
        tick();

        // byte lanes at the top word
        drv(0, 0, 1, 0, 10'h3FF, 4'hF, 32'h11223344);
        tick();
        drv(0, 0, 1, 0, 10'h3FF, 4'h2, 32'h0000AA00);
        tick();
        drv(0, 1, 0, 0, 10'h3FF, 4'hF, 32'h0);
        tick();
        idle_all();
        tick();
        chk("bytelane_rdv", 32'(smp_rdv0), 32'd1);
        chk("bytelane_data", smp_rd0, 32'h1122AA44);

        // reset right after an m1 read accept drops the return
        do_reset();
        drv(1, 1, 0, 0, 10'h020, 4'hF, 32'h0);
        tick();
        chk("rst_m1_accept", 32'(smp_wr1), 32'd0);
        idle_all();
        reset_n = 1'b0;
        tick();
        chk("rst_no_m1_rdv", 32'(smp_rdv1), 32'd0);
        chk("rst_wait0", 32'(smp_wr0), 32'd1);
        chk("rst_wait1", 32'(smp_wr1), 32'd1);
        tick();
        reset_n = 1'b1;
        drv(0, 1, 0, 0, 10'h010, 4'hF, 32'h0);
        drv(1, 1, 0, 0, 10'h020, 4'hF, 32'h0);
        tick();
        chk("rst_m0_first_w0", 32'(smp_wr0), 32'd0);
        chk("rst_m0_first_w1", 32'(smp_wr1), 32'd1);
        chk("rst_post_m1_rdv", 32'(smp_rdv1), 32'd0);
        idle_all();
        tick();

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                int op;
                op = int'($urandom_range(0, 3));
                drv(m, op == 1, op >= 2, ($urandom_range(0, 3) != 0),
                    10'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15)),
                    $urandom);
            end
            tick();
        end
        idle_all();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
